// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// sram_bus_arbiter : shares one SRAM-like bus between the IF fetch port and the
//                    MEM data port; data wins ties, pipeline stalls until done.
// Revision 1.0
// ============================================================================
module sram_bus_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inst_req,
   input  logic [ADDR_W-1:0]   inst_addr,
   output logic [DATA_W-1:0]   inst_rdata,
   output logic                inst_valid,
   input  logic                data_ce,
   input  logic                data_we,
   input  logic [DATA_W/8-1:0] data_sel,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_wdata,
   output logic [DATA_W-1:0]   data_rdata,
   output logic                data_valid,
   output logic                stall_o,
   output logic                bus_req,
   output logic                bus_wr,
   output logic [DATA_W/8-1:0] bus_wstrb,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   input  logic                bus_addr_ok,
   input  logic                bus_data_ok,
   input  logic [DATA_W-1:0]   bus_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t              state;
   state_t              next_state;
   logic                pend_d;
   logic                pend_i;
   logic                grant_d;
   logic                grant_i;
   logic                complete;
   logic                owner_data;
   logic                data_done;
   logic                inst_done;
   logic [ADDR_W-1:0]   lat_addr;
   logic                lat_we;
   logic [DATA_W/8-1:0] lat_sel;
   logic [DATA_W-1:0]   lat_wdata;

   always_comb begin
      pend_d     = data_ce & ~data_done;
      pend_i     = inst_req & ~inst_done;
      next_state = state;
      grant_d    = 1'b0;
      grant_i    = 1'b0;
      complete   = 1'b0;
      case (state)
         IDLE: begin
            if (pend_d) begin
               grant_d    = 1'b1;
               next_state = ADDR;
            end else if (pend_i) begin
               grant_i    = 1'b1;
               next_state = ADDR;
            end
         end
         ADDR: begin
            if (bus_addr_ok) begin
               if (bus_data_ok) begin
                  complete   = 1'b1;
                  next_state = IDLE;
               end else begin
                  next_state = WAIT;
               end
            end
         end
         WAIT: begin
            if (bus_data_ok) begin
               complete   = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign stall_o = pend_d | pend_i | (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         bus_req    <= 1'b0;
         owner_data <= 1'b0;
         lat_addr   <= '0;
         lat_we     <= 1'b0;
         lat_sel    <= '0;
         lat_wdata  <= '0;
         data_done  <= 1'b0;
         inst_done  <= 1'b0;
         data_rdata <= '0;
         inst_rdata <= '0;
         data_valid <= 1'b0;
         inst_valid <= 1'b0;
      end else begin
         state      <= next_state;
         bus_req    <= (next_state == ADDR);
         data_valid <= complete & owner_data;
         inst_valid <= complete & ~owner_data;
         if (grant_d | grant_i) begin
            owner_data <= grant_d;
            lat_addr   <= grant_d ? data_addr : inst_addr;
            lat_we     <= grant_d & data_we;
            lat_sel    <= grant_d ? data_sel : '0;
            lat_wdata  <= grant_d ? data_wdata : '0;
         end
         // Stores complete without touching the returned-data registers
         if (complete && !lat_we) begin
            if (owner_data) data_rdata <= bus_rdata;
            else            inst_rdata <= bus_rdata;
         end
         // Done flags hold off re-issue until the pipeline actually advances
         if (!stall_o) begin
            data_done <= 1'b0;
            inst_done <= 1'b0;
         end else if (complete) begin
            if (owner_data) data_done <= 1'b1;
            else            inst_done <= 1'b1;
         end
      end
   end

   assign bus_wr    = lat_we;
   assign bus_wstrb = lat_we ? lat_sel : '0;
   assign bus_addr  = lat_addr;
   assign bus_wdata = lat_wdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sram_bus_arbiter : directed and randomized access steps against a
//                       transaction-level model of the arbiter and bus slave.
// Revision 1.0
// ============================================================================
module tb_sram_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        inst_req = 1'b0;
   logic [31:0] inst_addr = '0;
   logic [31:0] inst_rdata;
   logic        inst_valid;
   logic        data_ce = 1'b0;
   logic        data_we = 1'b0;
   logic [3:0]  data_sel = '0;
   logic [31:0] data_addr = '0;
   logic [31:0] data_wdata = '0;
   logic [31:0] data_rdata;
   logic        data_valid;
   logic        stall_o;
   logic        bus_req;
   logic        bus_wr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_addr_ok;
   logic        bus_data_ok;
   logic [31:0] bus_rdata;

   logic        slv_aok = 1'b0;
   logic        slv_dok = 1'b0;
   logic [31:0] slv_rdata = '0;
   logic        man_en = 1'b0;
   logic        man_dok = 1'b0;
   logic [31:0] man_rdata = '0;

   assign bus_addr_ok = slv_aok;
   assign bus_data_ok = slv_dok | man_dok;
   assign bus_rdata   = man_en ? man_rdata : slv_rdata;

   int tests = 0;
   int fails = 0;
   int aw_cfg = 0;
   int dw_cfg = 1;
   logic [31:0] exp_drdata = '0;
   logic [31:0] exp_irdata = '0;

   typedef struct packed {
      logic [31:0] addr;
      logic        wr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } txn_t;
   txn_t txq[$];

   sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_valid(inst_valid),
      .data_ce(data_ce), .data_we(data_we), .data_sel(data_sel), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_rdata(data_rdata), .data_valid(data_valid),
      .stall_o(stall_o), .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
      .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'hDEADBEEF;
      return (a * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Bus slave: accepts after aw_cfg request cycles, responds dw_cfg cycles later
   logic slv_busy = 1'b0;
   int   slv_acnt = 0;
   int   slv_dcnt = 0;
   logic [31:0] slv_addr = '0;
   always @(negedge clk) begin
      slv_aok = 1'b0;
      slv_dok = 1'b0;
      if (!rst) begin
         slv_busy = 1'b0;
         slv_acnt = aw_cfg;
      end else if (slv_busy) begin
         if (slv_dcnt == 0) begin
            slv_dok   = 1'b1;
            slv_rdata = mem_word(slv_addr);
            slv_busy  = 1'b0;
            slv_acnt  = aw_cfg;
         end else begin
            slv_dcnt--;
         end
      end else if (bus_req) begin
         if (slv_acnt == 0) begin
            slv_aok = 1'b1;
            txq.push_back({bus_addr, bus_wr, bus_wstrb, bus_wdata});
            if (dw_cfg == 0) begin
               slv_dok   = 1'b1;
               slv_rdata = mem_word(bus_addr);
               slv_acnt  = aw_cfg;
            end else begin
               slv_busy = 1'b1;
               slv_dcnt = dw_cfg - 1;
               slv_addr = bus_addr;
            end
         end else begin
            slv_acnt--;
         end
      end else begin
         slv_acnt = aw_cfg;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One pipeline advance: every pending access costs a grant cycle,
   // aw+1 request cycles and dw response-wait cycles.
   task automatic step(input logic dce, input logic dwe, input logic [3:0] dsel,
                       input logic [31:0] daddr, input logic [31:0] dwdata,
                       input logic ireq, input logic [31:0] iaddr,
                       input int aw, input int dw, input logic keep);
      int n, exp_cyc, cyc, nreq, unstable, dv, iv, idx;
      logic done, pv;
      logic [68:0] prev;
      txn_t t;
      aw_cfg = aw;
      dw_cfg = dw;
      txq.delete();
      data_ce = dce; data_we = dwe; data_sel = dsel; data_addr = daddr; data_wdata = dwdata;
      inst_req = ireq; inst_addr = iaddr;
      n = int'(dce) + int'(ireq);
      exp_cyc = n * (aw + dw + 2);
      cyc = 0; nreq = 0; unstable = 0; dv = 0; iv = 0;
      done = 1'b0; pv = 1'b0; prev = '0;
      while (!done && cyc < 300) begin
         @(negedge clk);
         if (data_valid) dv++;
         if (inst_valid) iv++;
         if (bus_req) begin
            nreq++;
            if (pv && prev !== {bus_addr, bus_wr, bus_wstrb, bus_wdata}) unstable++;
            pv = 1'b1;
            prev = {bus_addr, bus_wr, bus_wstrb, bus_wdata};
         end else begin
            pv = 1'b0;
         end
         if (!stall_o) done = 1'b1;
         else cyc++;
      end
      check("stall_release", 32'(done), 32'd1);
      check("stall_cycles", cyc, exp_cyc);
      @(posedge clk);
      #1;
      if (!keep) begin
         data_ce = 1'b0;
         inst_req = 1'b0;
      end
      check("txn_count", txq.size(), n);
      check("req_cycles", nreq, n * (aw + 1));
      check("req_stable", unstable, 0);
      idx = 0;
      if (dce && txq.size() > idx) begin
         t = txq[idx];
         check("d_addr", t.addr, daddr);
         check("d_wr", 32'(t.wr), 32'(dwe));
         check("d_wstrb", 32'(t.wstrb), dwe ? 32'(dsel) : 32'd0);
         if (dwe) check("d_wdata", t.wdata, dwdata);
         idx++;
      end
      if (ireq && txq.size() > idx) begin
         t = txq[idx];
         check("i_addr", t.addr, iaddr);
         check("i_wr", 32'(t.wr), 32'd0);
         check("i_wstrb", 32'(t.wstrb), 32'd0);
      end
      if (dce && !dwe) exp_drdata = mem_word(daddr);
      if (ireq) exp_irdata = mem_word(iaddr);
      check("data_rdata", data_rdata, exp_drdata);
      check("inst_rdata", inst_rdata, exp_irdata);
      check("data_valid_cnt", dv, int'(dce));
      check("inst_valid_cnt", iv, int'(ireq));
   endtask

   initial begin
      int dv;
      logic rd, ri, rw;
      logic [3:0] rs;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_stall", 32'(stall_o), 32'd0);
      check("rst_bus_req", 32'(bus_req), 32'd0);
      check("rst_dvalid", 32'(data_valid), 32'd0);
      check("rst_ivalid", 32'(inst_valid), 32'd0);
      check("rst_drdata", data_rdata, 32'd0);
      check("rst_irdata", inst_rdata, 32'd0);
      check("rst_bus_addr", bus_addr, 32'd0);
      check("rst_wstrb", 32'(bus_wstrb), 32'd0);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;

      // single load
      step(1'b1, 1'b0, 4'b0000, 32'h100, 32'h0, 1'b0, 32'h0, 0, 1, 1'b0);
      // store and fetch together: data first, then instruction
      step(1'b1, 1'b1, 4'b1111, 32'h180, 32'h12345678, 1'b1, 32'h4000, 0, 1, 1'b0);
      // long address-phase backpressure, then same-cycle addr_ok/data_ok
      step(1'b1, 1'b1, 4'b0110, 32'h1C0, 32'hCAFEF00D, 1'b0, 32'h0, 5, 1, 1'b0);
      step(1'b1, 1'b0, 4'b0000, 32'h240, 32'h0, 1'b0, 32'h0, 0, 0, 1'b0);
      // byte store must leave load data alone
      step(1'b1, 1'b1, 4'b1000, 32'h203, 32'hAB000000, 1'b0, 32'h0, 0, 1, 1'b0);
      // fetch request held across three advances
      step(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 32'h8000, 0, 1, 1'b1);
      step(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 32'h8000, 0, 1, 1'b1);
      step(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 32'h8000, 0, 1, 1'b0);

      // randomized accesses and bus latencies
      for (int k = 0; k < 25; k++) begin
         rd = 1'($urandom_range(0, 1));
         rw = 1'($urandom_range(0, 1));
         ri = 1'($urandom_range(0, 1));
         rs = rw ? 4'($urandom_range(1, 15)) : 4'b0000;
         step(rd, rw, rs, $urandom, $urandom, ri, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
      end

      // reset while waiting for the response, then a stray data_ok
      aw_cfg = 0;
      dw_cfg = 20;
      data_ce = 1'b1; data_we = 1'b0; data_sel = 4'b0000; data_addr = 32'h300;
      repeat (3) @(negedge clk);
      check("wait_bus_req", 32'(bus_req), 32'd0);
      check("wait_stall", 32'(stall_o), 32'd1);
      #1 rst = 1'b0;
      data_ce = 1'b0;
      #1;
      check("mid_rst_stall", 32'(stall_o), 32'd0);
      check("mid_rst_bus_addr", bus_addr, 32'd0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      man_en = 1'b1; man_dok = 1'b1; man_rdata = 32'hBADBAD00;
      @(posedge clk);
      #1 man_dok = 1'b0;
      dv = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (data_valid) dv++;
         check("post_rst_bus_req", 32'(bus_req), 32'd0);
         check("post_rst_stall", 32'(stall_o), 32'd0);
      end
      check("post_rst_valid", dv, 0);
      check("post_rst_drdata", data_rdata, 32'd0);
      man_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
